// File: rtl/riscv_pkg.sv
// Shared types for the memory bus arbiter: FSM state, transaction owner
// and the width of the response watchdog counter.
package riscv_pkg;

    localparam int ARB_TMO_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_timeout.sv
// Response watchdog for the memory arbiter. Counts cycles spent waiting for
// mem_rvalid_i; expired_o marks the last cycle the arbiter will wait.
module mem_arb_timeout
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [ARB_TMO_W-1:0] cnt_q;
    logic [ARB_TMO_W-1:0] cnt_d;

    // Clear wins over enable so a grant always restarts the wait window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == ARB_TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between the IFU (requester 0) and
// the LSU (requester 1), one outstanding transaction at a time. The winner
// is locked until granted and its response is routed back to it; a watchdog
// forces an error response when memory never answers.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration
// instead of fixed LSU priority.
//
// state    | meaning
// ARB_IDLE | no transaction; arbitrate and present the winner to memory
// ARB_HOLD | winner locked, waiting for mem_gnt_i
// ARB_RESP | granted, waiting for mem_rvalid_i or watchdog expiry
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ifu_req_i,
    input  logic [XLEN-1:0]   ifu_addr_i,
    output logic              ifu_gnt_o,
    output logic              ifu_rvalid_o,
    output logic [XLEN-1:0]   ifu_rdata_o,
    output logic              ifu_err_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    input  logic [XLEN/8-1:0] lsu_wstrb_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_err_i
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e winner;
    arb_owner_e sel_owner;
    logic       sel_req;
    logic       drive_bus;
    logic       grant;
    logic       resp_valid;
    logic       expired;

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_owner_q, last_owner_d;
`endif

    // Pick the requester that would win if arbitration happened this cycle.
    always_comb begin
        winner = OWN_IFU;
`ifdef MEM_ARB_RR_EN
        if (lsu_req_i && ifu_req_i) begin
            winner = (last_owner_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_req_i) begin
            winner = OWN_LSU;
        end
`else
        if (lsu_req_i) begin
            winner = OWN_LSU;
        end
`endif
    end

    // Outside IDLE the locked owner is the only requester that can reach the bus.
    always_comb begin
        sel_owner  = (state_q == ARB_IDLE) ? winner : owner_q;
        sel_req    = (sel_owner == OWN_LSU) ? lsu_req_i : ifu_req_i;
        drive_bus  = (state_q != ARB_RESP) && sel_req;
        grant      = drive_bus && mem_gnt_i;
        resp_valid = (state_q == ARB_RESP) && (mem_rvalid_i || expired);
    end

    // Bus and requester outputs; everything is forced to 0 while in reset.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_wstrb_o  = '0;
        ifu_gnt_o    = 1'b0;
        ifu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        ifu_err_o    = 1'b0;
        lsu_gnt_o    = 1'b0;
        lsu_rvalid_o = 1'b0;
        lsu_rdata_o  = '0;
        lsu_err_o    = 1'b0;
        if (rst_ni) begin
            if (drive_bus) begin
                mem_req_o = 1'b1;
                if (sel_owner == OWN_LSU) begin
                    mem_we_o    = lsu_we_i;
                    mem_addr_o  = lsu_addr_i;
                    mem_wdata_o = lsu_wdata_i;
                    mem_wstrb_o = lsu_wstrb_i;
                end else begin
                    mem_addr_o = ifu_addr_i;
                end
            end
            if (grant) begin
                ifu_gnt_o = (sel_owner == OWN_IFU);
                lsu_gnt_o = (sel_owner == OWN_LSU);
            end
            // A real response takes precedence over a watchdog expiry in the same cycle.
            if (resp_valid) begin
                if (owner_q == OWN_LSU) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_err_o    = mem_rvalid_i ? mem_err_i : 1'b1;
                    lsu_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
                end else begin
                    ifu_rvalid_o = 1'b1;
                    ifu_err_o    = mem_rvalid_i ? mem_err_i : 1'b1;
                    ifu_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
                end
            end
        end
    end

    // Next-state and owner lock.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (drive_bus) begin
                    owner_d = winner;
                    state_d = mem_gnt_i ? ARB_RESP : ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (grant) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (resp_valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was granted last so simultaneous requests alternate.
    always_comb begin
        last_owner_d = grant ? sel_owner : last_owner_q;
    end

    // Round-robin history register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_owner_q <= OWN_LSU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // FSM and owner registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IFU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    mem_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (grant),
        .en_i      ((state_q == ARB_RESP) && !resp_valid),
        .expired_o (expired)
    );

`ifndef SYNTHESIS
    // The locked owner must keep requesting until it is granted.
    a_hold_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_HOLD) |-> sel_req);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default build: fixed LSU priority,
// TIMEOUT_CYCLES = 16). Inputs change 1 ns after the rising edge and
// outputs are checked 1 ns later, well before the next edge.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TMO  = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              ifu_req_i;
    logic [XLEN-1:0]   ifu_addr_i;
    logic              ifu_gnt_o, ifu_rvalid_o, ifu_err_o;
    logic [XLEN-1:0]   ifu_rdata_o;
    logic              lsu_req_i, lsu_we_i;
    logic [XLEN-1:0]   lsu_addr_i, lsu_wdata_i;
    logic [XLEN/8-1:0] lsu_wstrb_i;
    logic              lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [XLEN-1:0]   lsu_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [XLEN-1:0]   mem_addr_o, mem_wdata_o;
    logic [XLEN/8-1:0] mem_wstrb_o;
    logic              mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [XLEN-1:0]   mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ifu_req_i    (ifu_req_i),
        .ifu_addr_i   (ifu_addr_i),
        .ifu_gnt_o    (ifu_gnt_o),
        .ifu_rvalid_o (ifu_rvalid_o),
        .ifu_rdata_o  (ifu_rdata_o),
        .ifu_err_o    (ifu_err_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_wstrb_i  (lsu_wstrb_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_err_o    (lsu_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // All requester-visible outputs idle.
    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"}, mem_req_o, 0);
        chk({tag, ".mem_we"}, mem_we_o, 0);
        chk({tag, ".mem_addr"}, mem_addr_o, 0);
        chk({tag, ".mem_wdata"}, mem_wdata_o, 0);
        chk({tag, ".mem_wstrb"}, mem_wstrb_o, 0);
        chk({tag, ".ifu_any"}, {ifu_gnt_o, ifu_rvalid_o, ifu_err_o}, 0);
        chk({tag, ".lsu_any"}, {lsu_gnt_o, lsu_rvalid_o, lsu_err_o}, 0);
        chk({tag, ".ifu_rdata"}, ifu_rdata_o, 0);
        chk({tag, ".lsu_rdata"}, lsu_rdata_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        ifu_req_i = 0; ifu_addr_i = 0;
        lsu_req_i = 0; lsu_we_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_wstrb_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
        #2;
        chk_all_zero("reset");
        // Requests during reset must not leak to the bus.
        lsu_req_i = 1; ifu_req_i = 1; lsu_addr_i = 32'h44; mem_gnt_i = 1;
        #1;
        chk_all_zero("reset_req");
        lsu_req_i = 0; ifu_req_i = 0; lsu_addr_i = 0; mem_gnt_i = 0;
        tick();
        rst_ni = 1'b1;

        // LSU read, immediate grant, response two cycles later.
        tick();
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h100; mem_gnt_i = 1;
        #1;
        chk("t1.lsu_gnt", lsu_gnt_o, 1);
        chk("t1.mem_req", mem_req_o, 1);
        chk("t1.mem_addr", mem_addr_o, 32'h100);
        chk("t1.ifu_gnt", ifu_gnt_o, 0);
        tick();
        lsu_req_i = 0; mem_gnt_i = 0;
        #1;
        chk("t1.c1_gnt", lsu_gnt_o, 0);
        chk("t1.c1_rvalid", lsu_rvalid_o, 0);
        chk("t1.c1_mem_req", mem_req_o, 0);
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1.lsu_rvalid", lsu_rvalid_o, 1);
        chk("t1.lsu_rdata", lsu_rdata_o, 32'hDEADBEEF);
        chk("t1.lsu_err", lsu_err_o, 0);
        chk("t1.ifu_out", {ifu_gnt_o, ifu_rvalid_o, ifu_err_o}, 0);
        chk("t1.ifu_rdata", ifu_rdata_o, 0);
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;

        // Simultaneous requests: LSU first, IFU after LSU's response; IFU gets an error response.
        lsu_req_i = 1; lsu_addr_i = 32'h180; ifu_req_i = 1; ifu_addr_i = 32'h80; mem_gnt_i = 1;
        #1;
        chk("t2.lsu_gnt", lsu_gnt_o, 1);
        chk("t2.ifu_gnt", ifu_gnt_o, 0);
        chk("t2.mem_addr", mem_addr_o, 32'h180);
        tick();
        lsu_req_i = 0;
        #1;
        chk("t2.resp_no_gnt", {ifu_gnt_o, mem_req_o}, 0);
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0A0A;
        #1;
        chk("t2.lsu_rvalid", lsu_rvalid_o, 1);
        chk("t2.lsu_rdata", lsu_rdata_o, 32'h0000_0A0A);
        chk("t2.no_overlap", ifu_gnt_o, 0);
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        #1;
        chk("t2.ifu_gnt", ifu_gnt_o, 1);
        chk("t2.ifu_addr", mem_addr_o, 32'h80);
        chk("t2.ifu_we", {mem_we_o, mem_wstrb_o}, 0);
        tick();
        ifu_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hCAFE0001;
        #1;
        chk("t5.ifu_rvalid", ifu_rvalid_o, 1);
        chk("t5.ifu_err", ifu_err_o, 1);
        chk("t5.ifu_rdata", ifu_rdata_o, 32'hCAFE0001);
        chk("t5.lsu_rvalid", {lsu_rvalid_o, lsu_err_o}, 0);
        tick();
        mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;

        // IFU locked while memory stalls; LSU write arrives meanwhile.
        ifu_req_i = 1; ifu_addr_i = 32'h200;
        #1;
        chk("t3.c0_addr", mem_addr_o, 32'h200);
        chk("t3.c0_gnt", ifu_gnt_o, 0);
        tick();
        lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 32'h300; lsu_wdata_i = 32'h1234; lsu_wstrb_i = 4'b0011;
        #1;
        chk("t3.c1_addr", mem_addr_o, 32'h200);
        chk("t3.c1_we", mem_we_o, 0);
        chk("t3.c1_lsu_gnt", lsu_gnt_o, 0);
        tick();
        #1;
        chk("t3.c2_addr", mem_addr_o, 32'h200);
        chk("t3.c2_lsu_gnt", lsu_gnt_o, 0);
        tick();
        mem_gnt_i = 1;
        #1;
        chk("t3.ifu_gnt", ifu_gnt_o, 1);
        chk("t3.lsu_gnt", lsu_gnt_o, 0);
        chk("t3.gnt_addr", mem_addr_o, 32'h200);
        tick();
        ifu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11;
        #1;
        chk("t3.ifu_rvalid", ifu_rvalid_o, 1);
        chk("t3.ifu_rdata", ifu_rdata_o, 32'h11);
        chk("t3.lsu_gnt_resp", lsu_gnt_o, 0);
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;

        // LSU write granted, memory never answers: watchdog error after TMO cycles.
        mem_gnt_i = 1;
        #1;
        chk("t4.lsu_gnt", lsu_gnt_o, 1);
        chk("t4.mem_we", mem_we_o, 1);
        chk("t4.mem_addr", mem_addr_o, 32'h300);
        chk("t4.mem_wdata", mem_wdata_o, 32'h1234);
        chk("t4.mem_wstrb", mem_wstrb_o, 4'b0011);
        tick();
        lsu_req_i = 0; lsu_we_i = 0; lsu_wdata_i = 0; lsu_wstrb_i = 0; mem_gnt_i = 0;
        for (int k = 1; k < TMO; k++) begin
            #1;
            chk("t4.wait_rvalid", {lsu_rvalid_o, lsu_err_o}, 0);
            tick();
        end
        #1;
        chk("t4.tmo_rvalid", lsu_rvalid_o, 1);
        chk("t4.tmo_err", lsu_err_o, 1);
        chk("t4.tmo_rdata", lsu_rdata_o, 0);
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #1;
        chk("t4.late_ignored", {lsu_rvalid_o, ifu_rvalid_o, lsu_err_o, ifu_err_o}, 0);
        chk("t4.late_rdata", lsu_rdata_o, 0);
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;

        // Reset in RESP drops the pending response.
        lsu_req_i = 1; lsu_addr_i = 32'h400; mem_gnt_i = 1;
        #1;
        chk("t6.lsu_gnt", lsu_gnt_o, 1);
        tick();
        lsu_req_i = 0; mem_gnt_i = 0;
        #1;
        rst_ni = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #1;
        chk_all_zero("t6.rst");
        tick();
        rst_ni = 1;
        #1;
        chk("t6.stale_rvalid", {lsu_rvalid_o, ifu_rvalid_o}, 0);
        chk("t6.stale_rdata", lsu_rdata_o, 0);
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        lsu_req_i = 1; lsu_addr_i = 32'h500; mem_gnt_i = 1;
        #1;
        chk("t6.new_gnt", lsu_gnt_o, 1);
        chk("t6.new_addr", mem_addr_o, 32'h500);
        tick();
        lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99;
        #1;
        chk("t6.new_rvalid", lsu_rvalid_o, 1);
        chk("t6.new_rdata", lsu_rdata_o, 32'h99);
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        #1;
        chk_all_zero("end_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
